fir_coef_ctrl: RTL

Runtime coefficient controller for the symmetric transposed-form FIR datapath. It accepts the unique half of a symmetric coefficient set over a valid/ready stream into a shadow bank. It then swaps the shadow bank into the active bank on a sample boundary, so the filter never sees a partly updated set. It sits between the configuration bus and the FIR, replacing the static file-loaded coefficients with a live, double-buffered register set.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_coef_bank.sv | 37 +++
 rtl/fir_coef_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: coefficient-controller FSM states and symmetric-tap helpers.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ARM   = 3'd3,
    SWAP  = 3'd4
  } fir_coef_state_e;

  // Unique coefficients of an odd-length symmetric filter (centre tap included).
  function automatic int unsigned num_unique(input int unsigned fir_length);
    return (fir_length - 1) / 2 + 1;
  endfunction

  // Index width able to hold 0..n (never zero bits, even for n == 1).
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// One coefficient bank: N x W register file with async clear, single write
// port and a flattened read port (entry k at bits [k*W +: W]).
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned N  = 26,
  parameter int unsigned W  = 16,
  parameter int unsigned AW = idx_width(N)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [W-1:0]    i_data,
  output logic [N*W-1:0]  o_data
);

  logic [W-1:0] mem_q [N];

  // Storage: cleared by reset, one entry written per enabled cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < N; k++) mem_q[k] <= '0;
    end else if (i_we) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (i_addr == AW'(k)) mem_q[k] <= i_data;
      end
    end
  end

  // Flatten the register file onto the read port.
  always_comb begin
    o_data = '0;
    for (int unsigned k = 0; k < N; k++) o_data[k*W +: W] = mem_q[k];
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Double-buffered runtime coefficient controller for the symmetric FIR.
// Loads the unique half of the coefficient set into the shadow bank over a
// valid/ready stream, then swaps banks on a sample strobe.
// Optional feature: define FIR_COEF_CHECKSUM_EN to require a trailing
// modulo-2^COEF_WIDTH checksum word that is verified before arming the swap.
module fir_coef_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned FIR_LENGTH = 51,
  parameter int unsigned COEF_WIDTH = 16,
  localparam int unsigned NUM_UNIQUE = num_unique(FIR_LENGTH)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_cfg_start,
  input  logic [COEF_WIDTH-1:0]            i_cfg_data,
  input  logic                             i_cfg_valid,
  output logic                             o_cfg_ready,
  input  logic                             i_sample_strobe,
  output logic [NUM_UNIQUE*COEF_WIDTH-1:0] o_coeffs,
  output logic                             o_bank_sel,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err
);

  localparam int unsigned     IDX_W    = idx_width(NUM_UNIQUE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNIQUE - 1);

  fir_coef_state_e           state_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      ready_q;
  logic                      bank_sel_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
`ifdef FIR_COEF_CHECKSUM_EN
  logic [COEF_WIDTH-1:0]     sum_q;
`endif

  logic                      restart;
  logic                      coef_beat;
  logic                      we0;
  logic                      we1;
  logic [NUM_UNIQUE*COEF_WIDTH-1:0] bank0_data;
  logic [NUM_UNIQUE*COEF_WIDTH-1:0] bank1_data;

  assign restart   = i_cfg_start &&
                     (state_q == LOAD || state_q == CHECK || state_q == ARM);
  assign coef_beat = (state_q == LOAD) && ready_q && i_cfg_valid && !i_cfg_start;

  // Shadow bank is always the one not currently selected.
  assign we0 = coef_beat &&  bank_sel_q;
  assign we1 = coef_beat && !bank_sel_q;

  fir_coef_bank #(
    .N  (NUM_UNIQUE),
    .W  (COEF_WIDTH),
    .AW (IDX_W)
  ) u_bank0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (we0),
    .i_addr  (idx_q),
    .i_data  (i_cfg_data),
    .o_data  (bank0_data)
  );

  fir_coef_bank #(
    .N  (NUM_UNIQUE),
    .W  (COEF_WIDTH),
    .AW (IDX_W)
  ) u_bank1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (we1),
    .i_addr  (idx_q),
    .i_data  (i_cfg_data),
    .o_data  (bank1_data)
  );

  // Load / arm / swap sequencing with registered handshake and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      bank_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (restart) begin
        // A new start while busy abandons the shadow contents and reloads.
        err_q   <= 1'b1;
        idx_q   <= '0;
        state_q <= LOAD;
        ready_q <= 1'b1;
        busy_q  <= 1'b1;
`ifdef FIR_COEF_CHECKSUM_EN
        sum_q   <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (i_cfg_start) begin
              state_q <= LOAD;
              idx_q   <= '0;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
`ifdef FIR_COEF_CHECKSUM_EN
              sum_q   <= '0;
`endif
            end
          end
          LOAD: begin
            if (ready_q && i_cfg_valid) begin
              idx_q <= idx_q + IDX_W'(1);
`ifdef FIR_COEF_CHECKSUM_EN
              sum_q <= sum_q + i_cfg_data;
`endif
              if (idx_q == LAST_IDX) begin
                idx_q <= '0;
`ifdef FIR_COEF_CHECKSUM_EN
                // Ready stays high: the checksum word is taken in CHECK.
                state_q <= CHECK;
`else
                state_q <= ARM;
                ready_q <= 1'b0;
`endif
              end
            end
          end
`ifdef FIR_COEF_CHECKSUM_EN
          CHECK: begin
            if (ready_q && i_cfg_valid) begin
              ready_q <= 1'b0;
              if (i_cfg_data == sum_q) begin
                state_q <= ARM;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
`endif
          ARM: begin
            if (i_sample_strobe) state_q <= SWAP;
          end
          SWAP: begin
            bank_sel_q <= ~bank_sel_q;
            done_q     <= 1'b1;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_coeffs    = bank_sel_q ? bank1_data : bank0_data;
  assign o_cfg_ready = ready_q;
  assign o_bank_sel  = bank_sel_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
